// File: rtl/sw_result_ctrl.sv
// Packs Smith-Waterman parser scores and per-query summaries into one ordered FWFT record FIFO.
// Optional macro RESULT_THRESH_EN adds thresh_i and filters score records below it.
module sw_result_ctrl #(
  parameter int SCORE_W = 16,
  parameter int IDX_W   = 10,
  parameter int DEPTH   = 8,
  parameter int AFULL   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic [SCORE_W-1:0] result_i,
  input  logic               change_q_i,
  input  logic [SCORE_W-1:0] max_result_i,
  input  logic [IDX_W-1:0]   match_idx_i,
  input  logic               clr_i,
`ifdef RESULT_THRESH_EN
  input  logic [SCORE_W-1:0] thresh_i,
`endif
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_type_o,
  output logic [SCORE_W-1:0] out_score_o,
  output logic [IDX_W-1:0]   out_idx_o,
  output logic               stall_o,
  output logic               overflow_o,
  output logic [15:0]        query_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 1 + SCORE_W + IDX_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_C = CW'(DEPTH - AFULL);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  logic [RW-1:0]    mem [DEPTH];
  logic [AW-1:0]    rptr, wptr, wptr1;
  logic [CW-1:0]    count, count_nxt, free;
  logic [IDX_W-1:0] tcnt;
  logic             pop, score_req, score_acc, sum_acc, drop;
  logic             w0_en, w1_en;
  logic [RW-1:0]    score_rec, sum_rec, w0_data, head;

  assign out_valid_o = (count != '0);
  assign head        = mem[rptr];
  assign wptr1       = wptr + 1'b1;
  assign score_rec   = {1'b0, result_i, tcnt};
  assign sum_rec     = {1'b1, max_result_i, match_idx_i};

  // Outputs are forced to zero while empty so the reset values hold without resetting the array.
  assign out_type_o  = out_valid_o & head[RW-1];
  assign out_score_o = out_valid_o ? head[RW-2:IDX_W] : '0;
  assign out_idx_o   = out_valid_o ? head[IDX_W-1:0] : '0;

  always_comb begin
    pop       = out_valid_o & out_ready_i;
    free      = DEPTH_C - count + CW'(pop);
`ifdef RESULT_THRESH_EN
    score_req = valid_i && (result_i >= thresh_i);
`else
    score_req = valid_i;
`endif
    // Score record takes the first free slot; the summary only gets the second one.
    score_acc = score_req && (free != '0);
    sum_acc   = change_q_i && (score_acc ? (free >= TWO_C) : (free != '0));
    drop      = (score_req & ~score_acc) | (change_q_i & ~sum_acc);
    w0_en     = score_acc | sum_acc;
    w1_en     = score_acc & sum_acc;
    w0_data   = score_acc ? score_rec : sum_rec;
    count_nxt = count - CW'(pop) + CW'(score_acc) + CW'(sum_acc);
  end

  always_ff @(posedge clk) begin
    if (!clr_i) begin
      if (w0_en) mem[wptr]  <= w0_data;
      if (w1_en) mem[wptr1] <= sum_rec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      tcnt        <= '0;
      stall_o     <= 1'b0;
      overflow_o  <= 1'b0;
      query_cnt_o <= '0;
    end else if (clr_i) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      tcnt        <= '0;
      stall_o     <= 1'b0;
      overflow_o  <= 1'b0;
      query_cnt_o <= '0;
    end else begin
      if (pop) rptr <= rptr + 1'b1;
      wptr        <= wptr + AW'(w0_en) + AW'(w1_en);
      count       <= count_nxt;
      stall_o     <= (count_nxt >= STALL_C);
      overflow_o  <= overflow_o | drop;
      query_cnt_o <= query_cnt_o + 16'(sum_acc);
      if (change_q_i)   tcnt <= '0;
      else if (valid_i) tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sw_result_ctrl.sv
// Self-checking bench for sw_result_ctrl: queue-based reference model, directed cases, random traffic.
module tb_sw_result_ctrl;
  localparam int SCORE_W = 16;
  localparam int IDX_W   = 10;
  localparam int DEPTH   = 8;
  localparam int AFULL   = 2;
  localparam int RW      = 1 + SCORE_W + IDX_W;

  logic clk = 1'b0;
  logic rst_n, valid, chg, clr, rdy;
  logic [SCORE_W-1:0] res, mx, thresh;
  logic [IDX_W-1:0]   ix;
  logic out_valid, out_type, stall, ovf;
  logic [SCORE_W-1:0] out_score;
  logic [IDX_W-1:0]   out_idx;
  logic [15:0]        qcnt;

  always #5 clk = ~clk;

  sw_result_ctrl #(.SCORE_W(SCORE_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .result_i(res), .change_q_i(chg),
    .max_result_i(mx), .match_idx_i(ix), .clr_i(clr),
`ifdef RESULT_THRESH_EN
    .thresh_i(thresh),
`endif
    .out_valid_o(out_valid), .out_ready_i(rdy), .out_type_o(out_type),
    .out_score_o(out_score), .out_idx_o(out_idx), .stall_o(stall),
    .overflow_o(ovf), .query_cnt_o(qcnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [RW-1:0]    q[$];
  logic [IDX_W-1:0] m_tcnt;
  logic [15:0]      m_qcnt;
  logic             m_ovf, m_stall;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_tcnt = '0; m_qcnt = '0; m_ovf = 1'b0; m_stall = 1'b0;
  endfunction

  function automatic void model_update();
    logic pass;
    if (clr) begin
      model_reset();
      return;
    end
    if (rdy && q.size() > 0) void'(q.pop_front());
`ifdef RESULT_THRESH_EN
    pass = valid && (res >= thresh);
`else
    pass = valid;
`endif
    if (pass) begin
      if (q.size() < DEPTH) q.push_back({1'b0, res, m_tcnt});
      else m_ovf = 1'b1;
    end
    if (chg) begin
      if (q.size() < DEPTH) begin
        q.push_back({1'b1, mx, ix});
        m_qcnt++;
      end else m_ovf = 1'b1;
    end
    if (chg) m_tcnt = '0;
    else if (valid) m_tcnt++;
    m_stall = (q.size() >= DEPTH - AFULL);
  endfunction

  function automatic void compare();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_type", 32'(out_type), 32'(q[0][RW-1]));
      chk("out_score", 32'(out_score), 32'(q[0][RW-2:IDX_W]));
      chk("out_idx", 32'(out_idx), 32'(q[0][IDX_W-1:0]));
    end
    chk("stall", 32'(stall), 32'(m_stall));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("query_cnt", 32'(qcnt), 32'(m_qcnt));
  endfunction

  // Called at a falling edge: drive, advance model, clock, compare at the next falling edge.
  task automatic step(input logic v, input logic [15:0] r, input logic c, input logic [15:0] m,
                      input logic [9:0] i, input logic rd, input logic cl);
    valid = v; res = r; chg = c; mx = m; ix = i; rdy = rd; clr = cl;
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic expect_head(input logic t, input logic [15:0] s, input logic [9:0] i);
    chk("head_valid", 32'(out_valid), 32'd1);
    chk("head_type", 32'(out_type), 32'(t));
    chk("head_score", 32'(out_score), 32'(s));
    chk("head_idx", 32'(out_idx), 32'(i));
  endtask

  task automatic idle(input logic rd);
    step(1'b0, 16'd0, 1'b0, 16'd0, 10'd0, rd, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 0; chg = 0; clr = 0; rdy = 0;
    res = '0; mx = '0; ix = '0; thresh = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_type", 32'(out_type), 32'd0);
    chk("rst_score", 32'(out_score), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_qcnt", 32'(qcnt), 32'd0);
    rst_n = 1'b1;

    // Basic query: three scores then summary
    step(1, 16'd5, 0, 0, 0, 0, 0);
    chk("first_latency", 32'(out_valid), 32'd1);
    step(1, 16'd9, 0, 0, 0, 0, 0);
    step(1, 16'd2, 0, 0, 0, 0, 0);
    step(0, 16'd0, 1, 16'd9, 10'd1, 0, 0);
    chk("qcnt_one", 32'(qcnt), 32'd1);
    chk("model_depth4", 32'(q.size()), 32'd4);
    expect_head(0, 16'd5, 10'd0); idle(1);
    expect_head(0, 16'd9, 10'd1); idle(1);
    expect_head(0, 16'd2, 10'd2); idle(1);
    expect_head(1, 16'd9, 10'd1); idle(1);

    // Score and query end in the same cycle
    step(1, 16'd7, 1, 16'd7, 10'd4, 0, 0);
    step(1, 16'd3, 0, 0, 0, 0, 0);
    expect_head(0, 16'd7, 10'd0); idle(1);
    expect_head(1, 16'd7, 10'd4); idle(1);
    expect_head(0, 16'd3, 10'd0); idle(1);

    // Stall, overflow and flush
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      step(1, 16'(20 + k), 0, 0, 0, 0, 0);
      if (k == 4) chk("stall_at5", 32'(stall), 32'd0);
    end
    chk("stall_at6", 32'(stall), 32'd1);
    for (int k = 0; k < 3; k++) step(1, 16'(30 + k), 0, 0, 0, 0, 0);
    chk("ovf_set", 32'(ovf), 32'd1);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);

    // Full FIFO with a simultaneous pop and write
    for (int k = 0; k < DEPTH; k++) step(1, 16'(100 + k), 0, 0, 0, 0, 0);
    step(1, 16'd200, 0, 0, 0, 1, 0);
    chk("full_popwr_ovf", 32'(ovf), 32'd0);
    chk("full_popwr_depth", 32'(q.size()), 32'(DEPTH));
    expect_head(0, 16'd101, 10'd1);
    step(0, 0, 0, 0, 0, 0, 1);

`ifdef RESULT_THRESH_EN
    thresh = 16'd6;
    step(1, 16'd5, 0, 0, 0, 0, 0);
    step(1, 16'd9, 0, 0, 0, 0, 0);
    step(0, 0, 1, 16'd9, 10'd1, 0, 0);
    expect_head(0, 16'd9, 10'd1); idle(1);
    expect_head(1, 16'd9, 10'd1); idle(1);
    thresh = '0;
`endif

    // Reset mid-stream with four records buffered
    step(1, 16'd11, 0, 0, 0, 0, 0);
    step(1, 16'd12, 1, 16'd12, 10'd1, 0, 0);
    step(1, 16'd13, 0, 0, 0, 0, 0);
    chk("pre_rst_depth", 32'(q.size()), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_qcnt", 32'(qcnt), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_score", 32'(out_score), 32'd0);
    model_reset();
    valid = 0; chg = 0; clr = 0; rdy = 0;
    @(negedge clk);
    rst_n = 1'b1;
    compare();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
`ifdef RESULT_THRESH_EN
      thresh = 16'($urandom_range(0, 40));
`endif
      step(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 63)),
           1'($urandom_range(0, 7) == 0), 16'($urandom_range(0, 255)),
           10'($urandom_range(0, 1023)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sw_result_ctrl.md
# sw_result_ctrl

Result-collection controller that sits directly after the Smith-Waterman output parser. It packs the parser's per-target scores and per-query best-match summaries into one ordered record stream and buffers them in a FIFO. The stream leaves on a valid/ready handshake. The block also raises a stall request toward the target feeder before the buffer can overflow.

## Interface
Parameters:
- SCORE_W, 16: score width; equals the parser's calculation width.
- IDX_W, 10: target-index width; equals the parser's target-number width.
- DEPTH, 8: FIFO entries; power of two, at least 4.
- AFULL, 2: stall margin in free entries; 1 ≤ AFULL < DEPTH.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- valid_i, in, 1: parser score valid; one target score per cycle.
- result_i, in, SCORE_W: per-target local maximum score.
- change_q_i, in, 1: parser query-end pulse.
- max_result_i, in, SCORE_W: best score of the ending query; sampled with change_q_i.
- match_idx_i, in, IDX_W: target index of that best score; sampled with change_q_i.
- clr_i, in, 1: synchronous flush of FIFO, counters and overflow flag.
- out_valid_o, out, 1: head record valid.
- out_ready_i, in, 1: downstream accepts head record.
- out_type_o, out, 1: 0 = target-score record, 1 = query-summary record.
- out_score_o, out, SCORE_W: record score.
- out_idx_o, out, IDX_W: target index (score record) or match index (summary record).
- stall_o, out, 1: request to halt the target feed.
- overflow_o, out, 1: sticky flag; set when a record was dropped.
- query_cnt_o, out, 16: number of summaries written; wraps at 2^16.

## Operation
- Target counter tcnt (IDX_W bits):
  - Increments on every valid_i, including records filtered by the threshold; wraps modulo 2^IDX_W.
  - Returns to 0 after a change_q_i cycle.
- Score record: written on valid_i as {0, result_i, tcnt}.
- Summary record: written on change_q_i as {1, max_result_i, match_idx_i}.
- valid_i and change_q_i in the same cycle:
  - The score belongs to the ending query.
  - Score record is written first, summary second; two writes in one cycle.
  - tcnt then becomes 0.
- FIFO:
  - First-word-fall-through; out_* show the head entry.
  - Pop happens when out_valid_o & out_ready_i.
  - Capacity check counts a pop in the same cycle as a free slot: a write is accepted only if count − pop + (already-accepted writes this cycle) < DEPTH.
  - When a dual write has room for one entry, the score record is kept and the summary is dropped.
  - Each dropped record sets overflow_o.
  - query_cnt_o counts accepted summaries only.
- stall_o = (count ≥ DEPTH − AFULL); registered.
- clr_i:
  - Empties the FIFO and clears tcnt, query_cnt_o and overflow_o.
  - Overrides all writes in that cycle.
  - Takes priority over the handshake; a pop in that cycle is ignored.
- out_ready_i with out_valid_o low: no effect.
- Read and write pointers wrap modulo DEPTH.
- Reset mid-stream discards all buffered records.

## Timing
- Reset values: out_valid_o 0, out_type_o 0, out_score_o 0, out_idx_o 0, stall_o 0, overflow_o 0, query_cnt_o 0; internally count 0 and tcnt 0.
- Input-to-output latency:
  - Record written in cycle k appears on out_valid_o in cycle k+1 when the FIFO was empty.
  - Otherwise it appears after all older records have popped.
- Throughput: one pop per cycle; up to two writes per cycle.
- stall_o reflects count after the cycle-k updates, visible in cycle k+1.
- overflow_o is set in the cycle after the drop.
- out_* stay stable while out_valid_o & ~out_ready_i.

## Configuration
- Macro RESULT_THRESH_EN.
- Defined:
  - Adds input port thresh_i, SCORE_W bits.
  - Score records with result_i < thresh_i are not written; tcnt still advances.
  - Summary records are always written.
- Undefined:
  - No thresh_i port.
  - Every valid_i writes a score record.

## Test plan
- Reset, then valid_i for 3 cycles with results 5, 9, 2, then change_q_i with max 9, idx 1 → records (0,5,0), (0,9,1), (0,2,2), (1,9,1) in order; query_cnt_o = 1.
- valid_i and change_q_i together with result 7, max 7, idx 4 → (0,7,n) then (1,7,4); the next valid_i gets index 0.
- out_ready_i held 0 with DEPTH=8, AFULL=2, then 6 writes → stall_o = 1 the following cycle; 3 more writes → one dropped and overflow_o = 1; after clr_i → FIFO empty, overflow_o = 0.
- Full FIFO with out_ready_i = 1 and one write in the same cycle → write accepted, no overflow, count unchanged.
- RESULT_THRESH_EN defined, thresh_i = 6, results 5, 9 → only (0,9,1) written; summary still written.
- rst_n asserted mid-stream with 4 entries buffered → out_valid_o = 0 immediately; all outputs return to their reset values.
